// File: rtl/multichannel_upsampler.sv
// multichannel_upsampler: accepts one multi-channel frame via valid/ready and emits
// interpolation_l_p zero-stuffed or zero-order-hold frames, one every period_p cycles.
module multichannel_upsampler #(
    parameter int data_width_p      = 24,
    parameter int nr_of_channels_p  = 2,
    parameter int interpolation_l_p = 4,
    parameter int period_p          = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       mode,
    input  logic                                       clear,
    input  logic                                       x_valid,
    output logic                                       x_ready,
    input  logic [nr_of_channels_p*data_width_p-1:0]   x,
    output logic                                       y_valid,
    output logic [nr_of_channels_p*data_width_p-1:0]   y,
    output logic                                       y_first,
    output logic                                       y_last,
    output logic                                       underrun
);
    localparam int pw = interpolation_l_p > 1 ? $clog2(interpolation_l_p) : 1;
    localparam int cw = period_p > 1 ? $clog2(period_p) : 1;
    localparam logic [pw-1:0] phase_last = pw'(interpolation_l_p - 1);
    localparam logic [cw-1:0] cnt_last = cw'(period_p - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;
    logic [pw-1:0] phase, phase_d;
    logic [cw-1:0] period_cnt, period_cnt_d;
    logic [nr_of_channels_p*data_width_p-1:0] sample_r, sample_d, y_d;
    logic mode_r, mode_d, y_valid_d, y_first_d, y_last_d, underrun_d;
    logic accept, boundary;
    assign boundary = period_cnt == cnt_last;
    assign accept = x_valid && x_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            period_cnt <= '0;
            sample_r <= '0;
            mode_r <= 1'b0;
            y_valid <= 1'b0;
            y <= '0;
            y_first <= 1'b0;
            y_last <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= state_d;
            phase <= phase_d;
            period_cnt <= period_cnt_d;
            sample_r <= sample_d;
            mode_r <= mode_d;
            y_valid <= y_valid_d;
            y <= y_d;
            y_first <= y_first_d;
            y_last <= y_last_d;
            underrun <= underrun_d;
        end
    end
    always_comb begin
        state_d = state;
        phase_d = phase;
        period_cnt_d = period_cnt;
        sample_d = sample_r;
        mode_d = mode_r;
        y_valid_d = 1'b0;
        y_d = '0;
        y_first_d = 1'b0;
        y_last_d = 1'b0;
        underrun_d = underrun && !clear;
        if (accept) begin
            state_d = RUN;
            phase_d = '0;
            period_cnt_d = '0;
            sample_d = x;
            mode_d = mode;
            y_valid_d = 1'b1;
            y_d = x;
            y_first_d = 1'b1;
            y_last_d = interpolation_l_p == 1;
        end else if (state == RUN) begin
            period_cnt_d = boundary ? '0 : period_cnt + 1'b1;
            if (boundary && phase != phase_last) begin
                phase_d = phase + 1'b1;
                y_valid_d = 1'b1;
                y_d = mode_r ? sample_r : '0;
                y_last_d = phase_d == phase_last;
            end else if (boundary) begin
                // frame finished with nothing queued behind it
                state_d = IDLE;
                underrun_d = 1'b1;
            end
        end
    end
    always_comb x_ready = state == IDLE || (phase == phase_last && boundary);
endmodule

// File: tb/tb_multichannel_upsampler.sv
// tb_multichannel_upsampler: scoreboard bench for the default L=4/period 8 instance
// and an L=1/period 1 passthrough instance.
module tb_multichannel_upsampler;
    typedef struct {int c; logic [47:0] y; logic f; logic l;} exp_t;
    logic clk = 0, rst = 1;
    logic mode = 0, clear = 0, x_valid = 0, x_ready, y_valid, y_first, y_last, underrun;
    logic [47:0] x = '0, y;
    logic mode1 = 0, clear1 = 0, x1_valid = 0, x1_ready, y1_valid, y1_first, y1_last, underrun1;
    logic [47:0] x1 = '0, y1;
    int cyc = 0, checks = 0, errors = 0, e;
    exp_t q0[$], q1[$];
    localparam logic [47:0] fa = 48'h000123ABCDEF, fb = 48'h5A5A5A_0F0F0F, fc = 48'hFFFFFF_000001;
    multichannel_upsampler dut (
        .clk(clk), .rst(rst), .mode(mode), .clear(clear), .x_valid(x_valid), .x_ready(x_ready),
        .x(x), .y_valid(y_valid), .y(y), .y_first(y_first), .y_last(y_last), .underrun(underrun)
    );
    multichannel_upsampler #(.interpolation_l_p(1), .period_p(1)) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .clear(clear1), .x_valid(x1_valid), .x_ready(x1_ready),
        .x(x1), .y_valid(y1_valid), .y(y1), .y_first(y1_first), .y_last(y1_last), .underrun(underrun1)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] ex);
        checks++;
        assert (o === ex) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, ex);
        end
    endtask
    always @(negedge clk) begin
        exp_t t;
        if (y_valid) begin
            chk("pulse_expected", 64'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                t = q0.pop_front();
                chk("y_cycle", 64'(cyc), 64'(t.c));
                chk("y_data", {16'h0, y}, {16'h0, t.y});
                chk("y_first", 64'(y_first), 64'(t.f));
                chk("y_last", 64'(y_last), 64'(t.l));
            end
        end else chk("idle_zero", {14'h0, y, y_first, y_last}, 0);
    end
    always @(negedge clk) begin
        exp_t t;
        if (y1_valid) begin
            chk("l1_pulse_expected", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                t = q1.pop_front();
                chk("l1_cycle", 64'(cyc), 64'(t.c));
                chk("l1_data", {16'h0, y1}, {16'h0, t.y});
                chk("l1_first_last", {62'h0, y1_first, y1_last}, 64'h3);
            end
        end
    end
    task automatic send(input logic [47:0] d, input logic m, input bit hold, output int ea);
        int n = 0;
        x = d;
        mode = m;
        x_valid = 1;
        while (!x_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(x_ready), 1);
        ea = cyc + 1;
        for (int k = 0; k < 4; k++)
            q0.push_back('{ea + k * 8, (k == 0 || m) ? d : 48'h0, k == 0, k == 3});
        @(negedge clk);
        if (!hold) x_valid = 0;
    endtask
    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q0.size() + q1.size()), 0);
    endtask
    task automatic pulse_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outputs", {y_valid, y, y_first, y_last, underrun}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", {x_ready, x1_ready, underrun1}, 3'b110);
        // single frame, zero-order-hold
        send(fa, 1, 0, e);
        drain();
        repeat (10) @(negedge clk);
        chk("t1_ready_underrun", {x_ready, underrun}, 2'b11);
        pulse_clear();
        chk("t6_clear", 64'(underrun), 0);
        // single frame, zero-stuff
        send(fa, 0, 0, e);
        drain();
        repeat (10) @(negedge clk);
        chk("t2_underrun", 64'(underrun), 1);
        pulse_clear();
        // streaming three frames back to back
        send(fa, 1, 1, e);
        send(fb, 0, 1, e);
        chk("t3_no_underrun_b", 64'(underrun), 0);
        send(fc, 1, 0, e);
        chk("t3_no_underrun_c", 64'(underrun), 0);
        drain();
        repeat (10) @(negedge clk);
        chk("t3_underrun", 64'(underrun), 1);
        pulse_clear();
        // clear coincident with a new underrun: set wins
        send(fb, 1, 0, e);
        while (cyc < e + 31) @(negedge clk);
        chk("t6_before_set", 64'(underrun), 0);
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("t6_set_wins", 64'(underrun), 1);
        drain();
        // reset during phase 2
        send(fc, 1, 0, e);
        while (cyc < e + 18) @(negedge clk);
        rst = 1;
        q0.delete();
        #1;
        chk("t5_rst_outputs", {y_valid, y, y_first, y_last, underrun}, 0);
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        chk("t5_idle_ready", {x_ready, underrun}, 2'b10);
        send(fa, 0, 0, e);
        drain();
        // L=1, period 1 passthrough
        x1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            x1 = 48'(i);
            chk("l1_ready", 64'(x1_ready), 1);
            q1.push_back('{cyc + 1, 48'(i), 1'b1, 1'b1});
            @(negedge clk);
        end
        x1_valid = 0;
        drain();
        @(negedge clk);
        chk("l1_underrun", 64'(underrun1), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
